// File: rtl/axil_mem_pkg.sv
// Shared types for the AXI4-Lite slave memory: response codes, channel FSM states, word-index helper.
package axil_mem_pkg;

   typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
   typedef enum logic [1:0] {WIDLE, WADDR, WDATA, WRESP} wr_state_t;
   typedef enum logic [1:0] {RIDLE, RWAIT, RRESP} rd_state_t;

   // Only 4- and 8-byte words exist, so a fixed shift replaces a divide.
   function automatic logic [63:0] word_idx(input logic [63:0] addr, input logic [63:0] base,
                                            input int unsigned bytes_per_word);
      logic [63:0] off;
      off = addr - base;
      return (bytes_per_word == 8) ? (off >> 3) : (off >> 2);
   endfunction

endpackage

// File: rtl/axil_mem_array.sv
// NUM_WORDS x DATA_W storage: byte-masked write port, read port registered in 1 cycle.
// Read sees pre-write contents on a same-cycle collision; async clear; never stalls.
module axil_mem_array
   import axil_mem_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = 16,
   localparam int IDX_W    = $clog2(NUM_WORDS),
   localparam int STRB_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdat,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              re,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdat
);

   logic [DATA_W-1:0] mem [NUM_WORDS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
         rdat <= '0;
      end else begin
         if (we) begin
            for (int b = 0; b < STRB_W; b++)
               if (wstrb[b]) mem[widx][b*8 +: 8] <= wdat[b*8 +: 8];
         end
         if (re) rdat <= mem[ridx];
      end
   end

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave memory with decoded window; bvalid 1 cycle after the last of AW/W, rvalid 1 cycle after AR
// (plus RD_LAT with AXIL_MEM_RD_LAT_EN); one outstanding transaction per channel, responses held until ready.
module axil_slave_mem
   import axil_mem_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          NUM_WORDS = 16,
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int          RD_LAT    = 2
) (
   input  logic                axi_clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rvalid,
   input  logic                rready
);

   localparam int unsigned BPW    = DATA_W / 8;
   localparam int          IDX_W  = $clog2(NUM_WORDS);
   localparam logic [63:0] SPAN   = 64'(NUM_WORDS) * 64'(BPW);

   // 65-bit subtract so an address below the base shows up as a borrow.
   function automatic logic hit(input logic [ADDR_W-1:0] a);
      logic [64:0] off;
      off = {1'b0, 64'(a)} - {1'b0, BASE_ADDR};
      return !off[64] && (off[63:0] < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(word_idx(64'(a), BASE_ADDR, BPW));
   endfunction

   wr_state_t           wr_state;
   logic [ADDR_W-1:0]   aw_addr_q;
   logic [DATA_W-1:0]   w_dat_q;
   logic [BPW-1:0]      w_strb_q;
   logic                aw_hs, w_hs, commit, c_hit;
   logic [ADDR_W-1:0]   c_addr;
   logic [DATA_W-1:0]   c_dat;
   logic [BPW-1:0]      c_strb;

   // Commit uses whichever half was held plus the half arriving this cycle.
   always_comb begin
      aw_hs  = awvalid && awready;
      w_hs   = wvalid && wready;
      c_addr = (wr_state == WADDR) ? aw_addr_q : awaddr;
      c_dat  = (wr_state == WDATA) ? w_dat_q : wdata;
      c_strb = (wr_state == WDATA) ? w_strb_q : wstrb;
      c_hit  = hit(c_addr);
      commit = 1'b0;
      case (wr_state)
         WIDLE:   commit = aw_hs && w_hs;
         WADDR:   commit = w_hs;
         WDATA:   commit = aw_hs;
         default: commit = 1'b0;
      endcase
   end

   always_ff @(posedge axi_clk or posedge rst) begin
      if (rst) begin
         wr_state  <= WIDLE;
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         bresp     <= OKAY;
         aw_addr_q <= '0;
         w_dat_q   <= '0;
         w_strb_q  <= '0;
      end else if (commit) begin
         wr_state <= WRESP;
         awready  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b1;
         bresp    <= c_hit ? OKAY : SLVERR;
      end else begin
         case (wr_state)
            WIDLE: begin
               awready <= 1'b1;
               wready  <= 1'b1;
               if (aw_hs) begin
                  wr_state  <= WADDR;
                  aw_addr_q <= awaddr;
                  awready   <= 1'b0;
               end else if (w_hs) begin
                  wr_state <= WDATA;
                  w_dat_q  <= wdata;
                  w_strb_q <= wstrb;
                  wready   <= 1'b0;
               end
            end
            WRESP: if (bready) begin
               wr_state <= WIDLE;
               bvalid   <= 1'b0;
               awready  <= 1'b1;
               wready   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   rd_state_t         rd_state;
   logic              rd_hit_q, ar_hs, ar_hit;
   logic [DATA_W-1:0] arr_rdat;

   assign ar_hs  = arvalid && arready;
   assign ar_hit = hit(araddr);
   assign rdata  = rd_hit_q ? arr_rdat : '0;

`ifdef AXIL_MEM_RD_LAT_EN
   logic [3:0] rd_cnt;
`else
   localparam int unused_rd_lat = RD_LAT;
`endif

   // The array is read at the AR handshake, so any added wait still returns the data as of that edge.
   always_ff @(posedge axi_clk or posedge rst) begin
      if (rst) begin
         rd_state <= RIDLE;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rresp    <= OKAY;
         rd_hit_q <= 1'b0;
`ifdef AXIL_MEM_RD_LAT_EN
         rd_cnt   <= '0;
`endif
      end else begin
         case (rd_state)
            RIDLE: begin
               arready <= 1'b1;
               if (ar_hs) begin
                  arready  <= 1'b0;
                  rd_hit_q <= ar_hit;
                  rresp    <= ar_hit ? OKAY : SLVERR;
`ifdef AXIL_MEM_RD_LAT_EN
                  rd_state <= RWAIT;
                  rd_cnt   <= 4'(RD_LAT);
`else
                  rd_state <= RRESP;
                  rvalid   <= 1'b1;
`endif
               end
            end
`ifdef AXIL_MEM_RD_LAT_EN
            RWAIT: begin
               rd_cnt <= rd_cnt - 4'd1;
               if (rd_cnt == 4'd1) begin
                  rd_state <= RRESP;
                  rvalid   <= 1'b1;
               end
            end
`endif
            RRESP: if (rready) begin
               rd_state <= RIDLE;
               rvalid   <= 1'b0;
               arready  <= 1'b1;
            end
            default: rd_state <= RIDLE;
         endcase
      end
   end

   axil_mem_array #(
      .DATA_W    (DATA_W),
      .NUM_WORDS (NUM_WORDS)
   ) u_array (
      .clk   (axi_clk),
      .rst   (rst),
      .we    (commit && c_hit),
      .widx  (idx(c_addr)),
      .wdat  (c_dat),
      .wstrb (c_strb),
      .re    (ar_hs),
      .ridx  (idx(araddr)),
      .rdat  (arr_rdat)
   );

endmodule
